// File: rtl/phase_accum_slave.sv
// Phase accumulator behind an AXI-Stream phase-increment slave.
// Accepted increments are latched into inc_reg; every output handshake adds
// inc_reg into phase_acc and the top OUT_W bits stream out toward the sine LUT.
module phase_accum_slave #(
  parameter int PHASE_W       = 32,
  parameter int OUT_W         = 16,
  parameter int READY_HOLDOFF = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               s_axis_phase_tvalid,
  output logic               s_axis_phase_tready,
  input  logic [PHASE_W-1:0] s_axis_phase_tdata,
  input  logic               s_axis_phase_tlast,
  output logic               m_axis_data_tvalid,
  input  logic               m_axis_data_tready,
  output logic [OUT_W-1:0]   m_axis_data_tdata,
  output logic               m_axis_data_tlast,
  output logic [15:0]        inc_change_cnt,
  output logic [15:0]        segment_cnt
);

  localparam int HW = (READY_HOLDOFF > 0) ? $clog2(READY_HOLDOFF + 1) : 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t             state, state_nxt;
  logic [PHASE_W-1:0] inc_reg;
  logic [PHASE_W-1:0] phase_acc;
  logic               carry_q;
  logic [HW-1:0]      holdoff_cnt;
  logic               tlast_prev;
  logic               s_acc;
  logic               m_hs;

  assign s_acc = s_axis_phase_tvalid & s_axis_phase_tready;
  assign m_hs  = m_axis_data_tvalid & m_axis_data_tready;

  // State register: leaves IDLE once, only reset returns it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state: first accepted increment starts the generator.
  always_comb begin
    state_nxt = state;
    if (state == IDLE && s_acc) state_nxt = RUN;
  end

  // Outputs decoded from state and holdoff; tready is forced low during reset.
  always_comb begin
    s_axis_phase_tready = !reset && (holdoff_cnt == '0);
    m_axis_data_tvalid  = (state == RUN);
  end

  // Ingress side: latch increment, run the ready holdoff, track change/segment counts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inc_reg        <= '0;
      holdoff_cnt    <= '0;
      tlast_prev     <= 1'b0;
      inc_change_cnt <= '0;
      segment_cnt    <= '0;
    end else if (s_acc) begin
      inc_reg     <= s_axis_phase_tdata;
      holdoff_cnt <= HW'(READY_HOLDOFF);
      tlast_prev  <= s_axis_phase_tlast;
      // The very first increment is a load, not a change.
      if (state == RUN && s_axis_phase_tdata != inc_reg && inc_change_cnt != 16'hFFFF)
        inc_change_cnt <= inc_change_cnt + 16'd1;
      if (s_axis_phase_tlast && !tlast_prev && segment_cnt != 16'hFFFF)
        segment_cnt <= segment_cnt + 16'd1;
    end else if (holdoff_cnt != '0) begin
      holdoff_cnt <= holdoff_cnt - HW'(1);
    end
  end

  // Accumulator advances only on output handshake, so data/tlast hold under backpressure.
  // An accept in the same cycle still sees the old inc_reg here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_acc <= '0;
      carry_q   <= 1'b0;
    end else if (m_hs) begin
      {carry_q, phase_acc} <= {1'b0, phase_acc} + {1'b0, inc_reg};
    end
  end

  assign m_axis_data_tdata = phase_acc[PHASE_W-1 -: OUT_W];
  assign m_axis_data_tlast = carry_q;

endmodule

// File: tb/tb_phase_accum_slave.sv
// Self-checking bench for phase_accum_slave: random and directed stimulus
// against a cycle-level behavioural model, plus literal pins of known samples.
module tb_phase_accum_slave;
  localparam int HO = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        s_tvalid = 1'b0, s_tlast = 1'b0, m_tready = 1'b0;
  logic [31:0] s_tdata = '0;
  wire         s_tready, m_tvalid, m_tlast;
  wire  [15:0] m_tdata, inc_cnt, seg_cnt;

  phase_accum_slave #(.PHASE_W(32), .OUT_W(16), .READY_HOLDOFF(HO)) dut (
    .clk(clk), .reset(reset),
    .s_axis_phase_tvalid(s_tvalid), .s_axis_phase_tready(s_tready),
    .s_axis_phase_tdata(s_tdata), .s_axis_phase_tlast(s_tlast),
    .m_axis_data_tvalid(m_tvalid), .m_axis_data_tready(m_tready),
    .m_axis_data_tdata(m_tdata), .m_axis_data_tlast(m_tlast),
    .inc_change_cnt(inc_cnt), .segment_cnt(seg_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: phase is the running sum of the increment in force at each handshake.
  logic        md_run, md_tl, md_tlprev;
  int          md_hold;
  logic [31:0] md_inc, md_ph;
  logic [15:0] md_chg, md_seg;
  wire         md_rdy = !reset && (md_hold == 0);
  wire         md_acc = s_tvalid && md_rdy;
  wire         md_h   = md_run && m_tready;
  wire  [32:0] md_sum = {1'b0, md_ph} + {1'b0, md_inc};

  // Model update on each rising edge, using the increment held before this edge.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      md_run <= 1'b0; md_tl <= 1'b0; md_tlprev <= 1'b0; md_hold <= 0;
      md_inc <= '0; md_ph <= '0; md_chg <= '0; md_seg <= '0;
    end else begin
      if (md_h) begin
        md_ph <= md_sum[31:0];
        md_tl <= md_sum[32];
      end
      if (md_acc) begin
        md_inc    <= s_tdata;
        md_hold   <= HO;
        md_tlprev <= s_tlast;
        md_run    <= 1'b1;
        if (md_run && s_tdata != md_inc && md_chg != 16'hFFFF) md_chg <= md_chg + 16'd1;
        if (s_tlast && !md_tlprev && md_seg != 16'hFFFF) md_seg <= md_seg + 16'd1;
      end else if (md_hold > 0) begin
        md_hold <= md_hold - 1;
      end
    end
  end

  // Captured output samples (one entry per handshake) for literal checks.
  logic [15:0] cap_d [0:4095];
  logic        cap_l [0:4095];
  int          cap_n = 0;
  logic        cap_on = 1'b0;

  // Compare every cycle on the falling edge, away from the active edge.
  always @(negedge clk) begin
    chk("s_tready",   s_tready, md_rdy);
    chk("m_tvalid",   m_tvalid, md_run);
    chk("m_tdata",    m_tdata,  md_ph[31:16]);
    chk("m_tlast",    m_tlast,  md_tl);
    chk("inc_chg",    inc_cnt,  md_chg);
    chk("seg_cnt",    seg_cnt,  md_seg);
    if (cap_on && m_tvalid && m_tready && cap_n < 4096) begin
      cap_d[cap_n] <= m_tdata;
      cap_l[cap_n] <= m_tlast;
      cap_n        <= cap_n + 1;
    end
  end

  task automatic wait_samples(input string nm, input int base, input int n, input int budget);
    int k;
    for (k = 0; k < budget && (cap_n - base) < n; k++) @(negedge clk);
    chk(nm, (cap_n - base) >= n, 1);
  endtask

  task automatic send_beat(input logic [31:0] d, input logic l);
    logic r;
    r = 1'b0;
    s_tvalid = 1'b1; s_tdata = d; s_tlast = l;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); r = s_tready;
      @(posedge clk); #2;
      if (r) break;
    end
    s_tvalid = 1'b0;
    chk("t6_beat_accepted", r, 1);
  endtask

  initial begin
    int base, ntl;
    logic [5:0] pat;
    logic [15:0] seg_base;

    repeat (3) @(posedge clk);
    #2 reset = 1'b0;

    // T1: idle after reset
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("t1_tready", s_tready, 1);
    chk("t1_mvalid", m_tvalid, 0);
    chk("t1_inc_cnt", inc_cnt, 0);
    chk("t1_seg_cnt", seg_cnt, 0);

    // T2 + T4: constant increment, always-ready sink, holdoff pattern
    @(posedge clk); #2;
    m_tready = 1'b1; s_tvalid = 1'b1; s_tdata = 32'h0051EB85; s_tlast = 1'b0;
    base = cap_n; cap_on = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); pat[5-i] = s_tready;
    end
    chk("t4_tready_pattern", pat, 6'b100100);
    wait_samples("t2_samples_seen", base, 805, 2000);
    chk("t2_s0", cap_d[base+0], 16'h0000);
    chk("t2_s1", cap_d[base+1], 16'h0051);
    chk("t2_s2", cap_d[base+2], 16'h00A3);
    chk("t2_s800", cap_d[base+800], 16'hFFFF);
    chk("t2_s801", cap_d[base+801], 16'h0051);
    chk("t2_s801_tlast", cap_l[base+801], 1);
    ntl = 0;
    for (int i = 0; i <= 800; i++) ntl += int'(cap_l[base+i]);
    chk("t2_no_early_tlast", ntl, 0);
    chk("t2_inc_cnt", inc_cnt, 0);

    // T3: half-scale increment gives alternating halves
    @(posedge clk); #2 s_tdata = 32'h80000000;
    repeat (10) @(posedge clk);
    #2 base = cap_n;
    wait_samples("t3_samples_seen", base, 8, 100);
    for (int i = 0; i < 7; i++) begin
      chk("t3_alt_data", cap_d[base+i+1], cap_d[base+i] ^ 16'h8000);
      chk("t3_alt_tlast", cap_l[base+i+1], !cap_l[base+i]);
    end
    chk("t3_inc_cnt", inc_cnt, 1);

    // T5: random traffic on both sides
    cap_on = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #2;
      m_tready = 1'($urandom_range(0, 1));
      s_tvalid = 1'($urandom_range(0, 1));
      s_tlast  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        1: s_tdata = $urandom;
        2: s_tdata = 32'h0;
        3: s_tdata = 32'h80000000;
        default: ;
      endcase
    end
    @(posedge clk); #2;
    s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;

    // T6: tlast runs, then reset mid-run and restart
    repeat (4) @(posedge clk);
    @(negedge clk); seg_base = seg_cnt;
    @(posedge clk); #2;
    send_beat(s_tdata, 1'b0);
    send_beat(s_tdata, 1'b1);
    send_beat(s_tdata, 1'b1);
    send_beat(s_tdata, 1'b0);
    send_beat(s_tdata, 1'b1);
    @(negedge clk);
    chk("t6_segments", seg_cnt - seg_base, 2);

    @(posedge clk); #2 reset = 1'b1;
    #1;
    chk("t6_rst_tready", s_tready, 0);
    chk("t6_rst_mvalid", m_tvalid, 0);
    chk("t6_rst_mdata", m_tdata, 0);
    chk("t6_rst_mlast", m_tlast, 0);
    chk("t6_rst_inc_cnt", inc_cnt, 0);
    chk("t6_rst_seg_cnt", seg_cnt, 0);
    @(posedge clk); #2;
    reset = 1'b0;
    s_tvalid = 1'b1; s_tdata = 32'h0051EB85; s_tlast = 1'b0; m_tready = 1'b1;
    base = cap_n; cap_on = 1'b1;
    wait_samples("t6_restart_seen", base, 3, 50);
    chk("t6_r0", cap_d[base+0], 16'h0000);
    chk("t6_r1", cap_d[base+1], 16'h0051);
    chk("t6_r2", cap_d[base+2], 16'h00A3);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
